sc_rx_port_arbiter: RTL
=======================

SC_RX_PORT_ARBITER -- requirements
Module: sc_rx_port_arbiter

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL provide: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: SCRxPortData  input  8  received byte from the SIE receive path.
REQ-004 SHALL provide: SCRxPortCntl  input  8  control/status tag for that byte.
REQ-005 SHALL provide: SCRxPortDValid  input  1  one-cycle strobe; data and control are valid.
REQ-006 SHALL provide: SCRxPortRdy  output  1  high when the block can accept a byte (FIFO not full).
REQ-007 SHALL provide: getPacketReq  input  1  packet receiver requests the receive stream.
REQ-008 SHALL provide: getPacketGnt  output  1  packet receiver owns the stream.
REQ-009 SHALL provide: getPacketData/getPacketCntl  output  8/8  byte and tag delivered to the packet receiver.
REQ-010 SHALL provide: getPacketDValid  output  1  one-cycle delivery strobe to the packet receiver.
REQ-011 SHALL provide: directCntlReq, directCntlGnt, directCntlData, directCntlCntl, directCntlDValid, with the same directions, widths and meanings as the getPacket set.
REQ-012 SHALL provide: rxOverflow  output  1  sticky flag; a byte was dropped.

Function
REQ-013 SHALL buffer {SCRxPortCntl, SCRxPortData} in a 4-entry, 16-bit FIFO.
REQ-014 SHALL push on SCRxPortDValid=1 when the FIFO is not full.
REQ-015 SHALL drive SCRxPortRdy = not full; SCRxPortRdy is combinational from the registered count.
REQ-016 SHALL, on SCRxPortDValid=1 while full, drop the byte, leave FIFO contents unchanged, and set rxOverflow=1 on the next edge.
REQ-017 SHALL hold rxOverflow until reset.
REQ-018 SHALL implement arbiter FSM states ST_INIT, ST_IDLE, ST_GP and ST_DC.
REQ-019 SHALL enter ST_INIT on reset and go from ST_INIT to ST_IDLE on the first clock edge after reset.
REQ-020 SHALL, in ST_IDLE, go to ST_GP with getPacketGnt=1 when getPacketReq=1; getPacket has priority.
REQ-021 SHALL, in ST_IDLE, go to ST_DC with directCntlGnt=1 when getPacketReq=0 and directCntlReq=1.
REQ-022 SHALL register both grant outputs, so a grant asserts one cycle after its request is sampled.
REQ-023 SHALL, in ST_GP, return to ST_IDLE with getPacketGnt=0 when getPacketReq=0; ST_DC likewise on directCntlReq=0.
REQ-024 SHALL ignore the other request while a grant is held (no pre-emption).
REQ-025 SHALL pop one entry per cycle only when in ST_GP or ST_DC with the corresponding Req=1 and the FIFO not empty.
REQ-026 SHALL not pop in the cycle a request drops; the remaining bytes stay buffered.
REQ-027 SHALL register popped entries onto the granted consumer's Data/Cntl, with DValid=1 for exactly that cycle.
REQ-028 SHALL hold the non-granted consumer's DValid at 0 and its Data/Cntl at their last values.
REQ-029 SHALL give a latency of 2 cycles with grant already held: push edge N, pop edge N+1, DValid high in the cycle after edge N+1.
REQ-030 SHALL, on simultaneous push and pop when not full, perform both and leave the count unchanged.
REQ-031 SHALL, on a pop from full plus a concurrent DValid, drop that byte (SCRxPortRdy was low).
REQ-032 SHALL wrap FIFO pointers modulo 4 and keep a 3-bit count in the range 0..4.
REQ-033 SHALL, while no grant is held, accumulate bytes until full, then overflow per REQ-016.

Reset
REQ-034 SHALL, on rst=0, immediately clear: FSM to ST_INIT; both Gnt=0; both DValid=0; all Data/Cntl=8'h00; rxOverflow=0; FIFO pointers and count=0 (FIFO flushed).
REQ-035 SHALL discard all buffered bytes and in-flight delivery on reset mid-packet.
REQ-036 SHALL, after reset release, reach ST_IDLE one edge later; SCRxPortRdy=1 throughout reset.

Structure
REQ-037 SHALL place the FSM state encodings (ST_INIT=2'b11, ST_IDLE=2'b00, ST_GP=2'b01, ST_DC=2'b10), FIFO depth 4 and entry width 16 in the shared USB slave-controller package.
REQ-038 SHALL implement the FIFO as one sub-module, sc_rx_fifo (push, pop, full, empty, count, async active-low reset); arbitration and output registers stay in the top.

Verification
REQ-039 SHALL cover: getPacketReq=1 held, push 8'hA5/8'h01 -> getPacketGnt=1 one cycle after Req, getPacketData=8'hA5, getPacketCntl=8'h01, getPacketDValid pulses 2 cycles after push; directCntlDValid stays 0.
REQ-040 SHALL cover: getPacketReq and directCntlReq rise in the same cycle -> getPacketGnt=1, directCntlGnt=0; after getPacketReq drops, directCntlGnt=1 two cycles later.
REQ-041 SHALL cover: no request, push 5 bytes 8'h10..8'h14 -> SCRxPortRdy=0 after the 4th byte, 8'h14 dropped, rxOverflow=1; then grant directCntl -> 8'h10..8'h13 delivered in order on consecutive cycles.
REQ-042 SHALL cover: with grant held, push every cycle for 10 cycles -> all 10 bytes delivered in order, count never exceeds 2, rxOverflow=0.
REQ-043 SHALL cover: 3 bytes buffered and grant held, rst=0 for one cycle -> all outputs at reset values immediately, nothing delivered afterwards, SCRxPortRdy=1.
REQ-044 SHALL cover: getPacketReq drops with 2 bytes buffered -> no further getPacketDValid; those 2 bytes are delivered to directCntl on its subsequent grant.

Source files
------------

// File: rtl/sc_rx_port_arbiter_pkg.sv
// sc_rx_port_arbiter_pkg: shared receive-port definitions (arbiter states, FIFO geometry).
package sc_rx_port_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GP   = 2'b01,
        ST_DC   = 2'b10,
        ST_INIT = 2'b11
    } arbState_t;
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_WIDTH = 16;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
endpackage

// File: rtl/sc_rx_fifo.sv
// sc_rx_fifo: small receive FIFO; pushes while full and pops while empty are ignored.
module sc_rx_fifo
    import sc_rx_port_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [FIFO_WIDTH-1:0] wrData,
    output logic [FIFO_WIDTH-1:0] rdData,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);
    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic doPush, doPop;
    assign full   = count == CNT_W'(FIFO_DEPTH);
    assign empty  = count == '0;
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdData = mem[rdPtr];
    // storage needs no reset: the pointers and count define what is valid
    always_ff @(posedge clk)
        if (doPush) mem[wrPtr] <= wrData;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop) rdPtr <= rdPtr + PTR_W'(1);
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);
        end
endmodule

// File: rtl/sc_rx_port_arbiter.sv
// sc_rx_port_arbiter: buffers SIE receive bytes and hands them to the getPacket or
// directCntl consumer, whichever holds the grant.
module sc_rx_port_arbiter
    import sc_rx_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] SCRxPortData,
    input  logic [7:0] SCRxPortCntl,
    input  logic       SCRxPortDValid,
    output logic       SCRxPortRdy,
    input  logic       getPacketReq,
    output logic       getPacketGnt,
    output logic [7:0] getPacketData,
    output logic [7:0] getPacketCntl,
    output logic       getPacketDValid,
    input  logic       directCntlReq,
    output logic       directCntlGnt,
    output logic [7:0] directCntlData,
    output logic [7:0] directCntlCntl,
    output logic       directCntlDValid,
    output logic       rxOverflow
);
    arbState_t state;
    logic [FIFO_WIDTH-1:0] head;
    logic full, empty, pop, popGp, popDc;
    logic [CNT_W-1:0] count;
    assign SCRxPortRdy = count != CNT_W'(FIFO_DEPTH);
    // a dropping request stops the pop in the same cycle so leftover bytes stay buffered
    assign popGp = !empty && state == ST_GP && getPacketReq;
    assign popDc = !empty && state == ST_DC && directCntlReq;
    assign pop   = popGp || popDc;

    sc_rx_fifo uFifo (
        .clk    (clk),
        .rst    (rst),
        .push   (SCRxPortDValid),
        .pop    (pop),
        .wrData ({SCRxPortCntl, SCRxPortData}),
        .rdData (head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state            <= ST_INIT;
            getPacketGnt     <= 1'b0;
            directCntlGnt    <= 1'b0;
            getPacketDValid  <= 1'b0;
            directCntlDValid <= 1'b0;
            getPacketData    <= 8'h00;
            getPacketCntl    <= 8'h00;
            directCntlData   <= 8'h00;
            directCntlCntl   <= 8'h00;
            rxOverflow       <= 1'b0;
        end else begin
            getPacketDValid  <= popGp;
            directCntlDValid <= popDc;
            if (popGp) {getPacketCntl, getPacketData} <= head;
            if (popDc) {directCntlCntl, directCntlData} <= head;
            if (SCRxPortDValid && full) rxOverflow <= 1'b1;
            case (state)
                ST_INIT: state <= ST_IDLE;
                ST_IDLE:
                    if (getPacketReq) begin
                        state        <= ST_GP;
                        getPacketGnt <= 1'b1;
                    end else if (directCntlReq) begin
                        state         <= ST_DC;
                        directCntlGnt <= 1'b1;
                    end
                ST_GP:
                    if (!getPacketReq) begin
                        state        <= ST_IDLE;
                        getPacketGnt <= 1'b0;
                    end
                ST_DC:
                    if (!directCntlReq) begin
                        state         <= ST_IDLE;
                        directCntlGnt <= 1'b0;
                    end
                default: state <= ST_IDLE;
            endcase
        end
endmodule
